// File: rtl/sa_pkg.sv
// ============================================================================
// Module      : sa_pkg
// Description : Shared types and constants for the 2x2 systolic-array host
//               feeder (state encoding, default widths, element counts).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } sa_state_t;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int ACC_WIDTH_DEF  = 9;
    localparam int N_OPERANDS     = 8;
    localparam int N_RESULTS      = 4;

endpackage

`default_nettype wire

// File: rtl/sa_host_feeder.sv
// ============================================================================
// Module      : sa_host_feeder
// Description : Collects eight operands from a stream, issues them to a 2x2
//               systolic array, and streams the four results back out.
//               Optional WAIT watchdog enabled by defining SA_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_host_feeder
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ACC_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic                  sa_in_valid,
    output logic [DATA_WIDTH-1:0] sa_a00,
    output logic [DATA_WIDTH-1:0] sa_a01,
    output logic [DATA_WIDTH-1:0] sa_a10,
    output logic [DATA_WIDTH-1:0] sa_a11,
    output logic [DATA_WIDTH-1:0] sa_b00,
    output logic [DATA_WIDTH-1:0] sa_b01,
    output logic [DATA_WIDTH-1:0] sa_b10,
    output logic [DATA_WIDTH-1:0] sa_b11,
    input  logic                  sa_out_valid,
    input  logic [ACC_WIDTH-1:0]  sa_c00,
    input  logic [ACC_WIDTH-1:0]  sa_c01,
    input  logic [ACC_WIDTH-1:0]  sa_c10,
    input  logic [ACC_WIDTH-1:0]  sa_c11,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W  = $clog2(N_OPERANDS);
    localparam int RIDX_W = $clog2(N_RESULTS);

    if (TIMEOUT_CYC < 1) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be at least 1");
    end

    sa_state_t             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [RIDX_W-1:0]     ridx_q, ridx_d;
    logic [DATA_WIDTH-1:0] op_q  [N_OPERANDS];
    logic [DATA_WIDTH-1:0] op_d  [N_OPERANDS];
    logic [ACC_WIDTH-1:0]  res_q [N_RESULTS];
    logic [ACC_WIDTH-1:0]  res_d [N_RESULTS];

`ifdef SA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ridx_q  <= '0;
            for (int i = 0; i < N_OPERANDS; i++) op_q[i] <= '0;
            for (int i = 0; i < N_RESULTS; i++)  res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ridx_q  <= ridx_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ridx_d      = ridx_q;
        op_d        = op_q;
        res_d       = res_q;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        sa_in_valid = 1'b0;
`ifdef SA_TIMEOUT_EN
        timeout     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Reset holds the FSM here, so gating with rstn keeps ready low during reset.
                s_ready = rstn;
                if (s_valid && rstn) begin
                    op_d[0] = s_data;
                    idx_d   = IDX_W'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    op_d[idx_q] = s_data;
                    if (idx_q == IDX_W'(N_OPERANDS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                sa_in_valid = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                sa_in_valid = 1'b1;
                if (sa_out_valid) begin
                    res_d[0] = sa_c00;
                    res_d[1] = sa_c01;
                    res_d[2] = sa_c10;
                    res_d[3] = sa_c11;
                    ridx_d   = '0;
                    state_d  = ST_DRAIN;
                end
`ifdef SA_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_DRAIN: begin
                m_valid = 1'b1;
                m_data  = res_q[ridx_q];
                m_last  = (ridx_q == RIDX_W'(N_RESULTS - 1));
                if (m_ready) begin
                    if (m_last) begin
                        ridx_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        ridx_d = ridx_q + RIDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SA_TIMEOUT_EN
    // Counts completed WAIT cycles; cleared whenever WAIT is left or not yet entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign err = timeout;
`else
    assign err = 1'b0;
`endif

    assign busy   = (state_q != ST_IDLE);
    assign sa_a00 = op_q[0];
    assign sa_a01 = op_q[1];
    assign sa_a10 = op_q[2];
    assign sa_a11 = op_q[3];
    assign sa_b00 = op_q[4];
    assign sa_b01 = op_q[5];
    assign sa_b10 = op_q[6];
    assign sa_b11 = op_q[7];

endmodule

`default_nettype wire

// File: tb/tb_sa_host_feeder.sv
// ============================================================================
// Module      : tb_sa_host_feeder
// Description : Self-checking bench for sa_host_feeder with a behavioural
//               2x2 array stub; covers the SA_TIMEOUT_EN build when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_host_feeder;

    localparam int DW = 4;
    localparam int AW = 9;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [AW-1:0] m_data;
    logic          sa_in_valid, sa_out_valid;
    logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
    logic [AW-1:0] c00, c01, c10, c11;
    logic          busy, err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_host_feeder #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .sa_in_valid(sa_in_valid),
        .sa_a00(a00), .sa_a01(a01), .sa_a10(a10), .sa_a11(a11),
        .sa_b00(b00), .sa_b01(b01), .sa_b10(b10), .sa_b11(b11),
        .sa_out_valid(sa_out_valid),
        .sa_c00(c00), .sa_c01(c01), .sa_c10(c10), .sa_c11(c11),
        .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Array stub: answers A*B five cycles after sa_in_valid rises, unless silenced.
    logic          stub_silent, stub_prev, stub_ov;
    int            stub_cnt;
    logic [AW-1:0] stub_c [4];
    logic          inj_ov;
    logic [AW-1:0] inj_val;

    always @(posedge clk) begin
        stub_ov <= 1'b0;
        if (!rstn) begin
            stub_cnt  <= 0;
            stub_prev <= 1'b0;
        end else begin
            stub_prev <= sa_in_valid;
            if (sa_in_valid && !stub_prev) begin
                stub_cnt <= 5;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && !stub_silent) begin
                    stub_ov   <= 1'b1;
                    stub_c[0] <= AW'(int'(a00) * int'(b00) + int'(a01) * int'(b10));
                    stub_c[1] <= AW'(int'(a00) * int'(b01) + int'(a01) * int'(b11));
                    stub_c[2] <= AW'(int'(a10) * int'(b00) + int'(a11) * int'(b10));
                    stub_c[3] <= AW'(int'(a10) * int'(b01) + int'(a11) * int'(b11));
                end
            end
        end
    end

    assign sa_out_valid = stub_ov | inj_ov;
    assign c00 = inj_ov ? inj_val          : stub_c[0];
    assign c01 = inj_ov ? inj_val + AW'(1) : stub_c[1];
    assign c10 = inj_ov ? inj_val + AW'(2) : stub_c[2];
    assign c11 = inj_ov ? inj_val + AW'(3) : stub_c[3];

    // Transaction-level model: operands gathered, job in flight, results queued.
    logic [DW-1:0] mod_ops [8];
    int            mod_nops = 0;
    bit            mod_act  = 1'b0;
    int            mod_acyc = 0;
    logic [AW-1:0] outq [$];
    logic [AW-1:0] out_log  [$];
    logic          last_log [$];
    logic          e_sr, e_mv, e_ml, e_err, e_busy, prev_iv = 1'b0;
    logic [AW-1:0] e_md;
    logic [DW-1:0] dut_ops [8];
    int            rise_cyc = 0, err_cyc = 0, err_cnt = 0;

    assign dut_ops = '{a00, a01, a10, a11, b00, b01, b10, b11};

    always @(negedge clk) begin
        if (!rstn) begin
            mod_nops = 0;
            mod_act  = 1'b0;
            mod_acyc = 0;
            outq.delete();
            for (int i = 0; i < 8; i++) mod_ops[i] = '0;
        end
        e_sr   = rstn && !mod_act && (outq.size() == 0);
        e_mv   = (outq.size() > 0);
        e_md   = e_mv ? outq[0] : '0;
        e_ml   = (outq.size() == 1);
        e_busy = (mod_nops > 0) || mod_act || e_mv;
        e_err  = 1'b0;
`ifdef SA_TIMEOUT_EN
        e_err  = mod_act && (mod_acyc == TO) && !sa_out_valid;
`endif
        chk("s_ready", s_ready, e_sr);
        chk("m_valid", m_valid, e_mv);
        chk("m_data", m_data, e_md);
        chk("m_last", m_last, e_mv && e_ml);
        chk("sa_in_valid", sa_in_valid, mod_act);
        chk("busy", busy, e_busy);
        chk("err", err, e_err);
        for (int i = 0; i < 8; i++) chk("operand", dut_ops[i], mod_ops[i]);

        if (sa_in_valid && !prev_iv) rise_cyc = cyc;
        prev_iv = sa_in_valid;
        if (err) begin
            err_cyc = cyc;
            err_cnt++;
        end
        if (m_valid && m_ready) begin
            out_log.push_back(m_data);
            last_log.push_back(m_last);
        end

        if (rstn) begin
            if (s_valid && e_sr) begin
                mod_ops[mod_nops] = s_data;
                mod_nops++;
                if (mod_nops == 8) begin
                    mod_nops = 0;
                    mod_act  = 1'b1;
                    mod_acyc = 0;
                end
            end else if (mod_act) begin
                if (mod_acyc >= 1 && sa_out_valid) begin
                    outq.push_back(c00);
                    outq.push_back(c01);
                    outq.push_back(c10);
                    outq.push_back(c11);
                    mod_act = 1'b0;
                end else if (e_err) begin
                    mod_act = 1'b0;
                end else begin
                    mod_acyc++;
                end
            end
            if (e_mv && m_ready) void'(outq.pop_front());
        end
    end

    logic [DW-1:0] job [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ops(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            s_valid = 1'b1;
            s_data  = job[i];
            @(negedge clk);
            while (!s_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) chk("send_timeout", guard, 0);
            step();
            s_valid = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (out_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("out_count", out_log.size(), n);
    endtask

    task automatic chk_results(input string tag, input int r0, input int r1,
                               input int r2, input int r3);
        int exp [4];
        exp = '{r0, r1, r2, r3};
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_data"}, (out_log.size() > i) ? 32'(out_log[i]) : 32'hDEAD, exp[i]);
            chk({tag, "_last"}, (last_log.size() > i) ? 32'(last_log[i]) : 32'hDEAD, (i == 3));
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic set_job_seq();
        for (int i = 0; i < 8; i++) job[i] = DW'(i + 1);
    endtask

    initial begin
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        inj_ov = 1'b0; inj_val = '0; stub_silent = 1'b0;
        repeat (3) step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_data", m_data, 0);
        rstn = 1'b1;
        step();
        chk("idle_s_ready", s_ready, 1);
        chk("idle_busy", busy, 0);

        // Spurious result in IDLE, then a gapped load
        inj_val = AW'(111); inj_ov = 1'b1;
        step();
        inj_ov = 1'b0;
        step();
        chk("spurious_busy", busy, 0);
        set_job_seq();
        out_log.delete(); last_log.delete();
        send_ops(8, 2);
        wait_out(4, 200);
        chk_results("basic", 19, 22, 43, 50);

        // Saturated operands: 15*15*2 = 450 needs all nine result bits
        for (int i = 0; i < 8; i++) job[i] = DW'(15);
        out_log.delete(); last_log.delete();
        send_ops(8, 0);
        wait_out(4, 200);
        chk_results("max", 450, 450, 450, 450);

        // Output back-pressure
        set_job_seq();
        out_log.delete(); last_log.delete();
        m_ready = 1'b0;
        send_ops(8, 0);
        begin
            int k = 0;
            @(negedge clk);
            while (!m_valid && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk("stall_reach", m_valid, 1);
            repeat (3) begin
                chk("stall_data", m_data, 19);
                chk("stall_valid", m_valid, 1);
                @(negedge clk);
            end
        end
        step();
        m_ready = 1'b1;
        wait_out(4, 100);
        chk_results("stall", 19, 22, 43, 50);

        // Reset mid-load abandons the job
        out_log.delete(); last_log.delete();
        send_ops(5, 0);
        rstn = 1'b0;
        step();
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_a00", a00, 0);
        chk("midrst_b00", b00, 0);
        chk("midrst_m_valid", m_valid, 0);
        rstn = 1'b1;
        repeat (3) step();
        chk("midrst_no_output", out_log.size(), 0);
        chk("midrst_idle_ready", s_ready, 1);
        send_ops(8, 1);
        wait_out(4, 200);
        chk_results("after_rst", 19, 22, 43, 50);

        // Silent array
        stub_silent = 1'b1;
        out_log.delete(); last_log.delete();
        err_cnt = 0;
        send_ops(8, 0);
`ifdef SA_TIMEOUT_EN
        begin
            int k = 0;
            while (err_cnt == 0 && k < 200) begin
                step();
                k++;
            end
            chk("err_seen", err_cnt, 1);
            chk("err_delay", err_cyc - rise_cyc, TO);
            chk("err_busy_next", busy, 0);
            repeat (10) step();
            chk("err_single", err_cnt, 1);
            chk("err_no_output", out_log.size(), 0);
        end
`else
        repeat (40) step();
        chk("hang_busy", busy, 1);
        chk("hang_err", err_cnt, 0);
        chk("hang_in_valid", sa_in_valid, 1);
        inj_val = AW'(5); inj_ov = 1'b1;
        step();
        inj_ov = 1'b0;
        wait_out(4, 100);
        chk_results("late", 5, 6, 7, 8);
`endif
        stub_silent = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
